mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multicycle control unit front end: main state machine, ALU decoder and PC logic for the ARM-subset multicycle core.
- Sits directly upstream of the conditional-logic stage. It supplies the unconditioned enables PCS, RegW, MemW and FlagW, which that stage gates with CondEx.
- Also drives all datapath mux selects plus IRWrite and NextPC.
- One instruction takes 3–5 cycles.

Parameters:
- ALUCTRL_W, 2, width of ALUControl; fixed by the datapath ALU encoding.
- RESULTSRC_W, 2, width of ResultSrc and ALUSrcB selects.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; returns FSM to FETCH
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- Rd  in  4  Instr[15:12]
- PCS  out  1  PC-source request (branch or write to R15), unconditioned
- NextPC  out  1  unconditional PC increment enable (FETCH)
- RegW  out  1  register-write request, unconditioned
- MemW  out  1  memory-write request, unconditioned
- FlagW  out  2  flag-write request [1]=NZ, [0]=CV, unconditioned
- IRWrite  out  1  instruction register load
- AdrSrc  out  1  0=PC, 1=ALUOut
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)

Behaviour:
- Moore FSM. State is registered; outputs are decoded combinationally from the current state and the instruction fields. No output registers.
- State updates on rising clk. reset=1 forces state FETCH at the next edge; a reset issued mid-instruction aborts it.
- While reset=1, all outputs take their FETCH-state values, except IRWrite, NextPC, RegW, MemW, PCS and FlagW, which are forced to 0.
- States, their asserted outputs (all unlisted outputs are 0), and next state:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0 -> DECODE
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 -> branch on Op:
    - Op=01 -> MEMADR
    - Op=00 with Funct[5]=0 -> EXECUTER
    - Op=00 with Funct[5]=1 -> EXECUTEI
    - Op=10 -> BRANCH
    - Op=11 -> FETCH (illegal; no side effects)
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0 -> MEMRD if Funct[0]=1, else MEMWR
  - MEMRD: AdrSrc=1, ResultSrc=00 -> MEMWB
  - MEMWB: ResultSrc=01, RegW=1 -> FETCH
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1 -> FETCH
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1 -> ALUWB
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1 -> ALUWB
  - ALUWB: ResultSrc=00, RegW=1 -> FETCH
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1 -> FETCH
- Unencoded state values recover to FETCH on the next edge.
- ALU decoder:
  - ALUOp=0: ALUControl=ADD, FlagW=00.
  - ALUOp=1, by Funct[4:1]: 0100=ADD, 0010=SUB, 0000=AND, 1100=ORR. Any other cmd gives ALUControl=ADD and FlagW=00.
  - FlagW[1]=Funct[0].
  - FlagW[0]=Funct[0] AND (ADD or SUB).
  - Result: FlagW is nonzero only in EXECUTER/EXECUTEI.
- PC logic: PCS = (RegW AND Rd==4'hF) OR Branch. It can therefore assert only in MEMWB, ALUWB or BRANCH.
- Latency: LDR=5 cycles, STR=4, data-processing=4, B=3, illegal=2.
- Inputs are sampled from the instruction register. Op/Funct/Rd must stay stable from DECODE through the end of the instruction; the FSM does not latch them itself.

Decomposition:
- Shared package ctrl_pkg holds:
  - state_t enum with the 10 states above
  - localparams for ALUControl codes (ALU_ADD/SUB/AND/ORR)
  - ResultSrc and ALUSrcB codes
  - Op codes (OP_DP=00, OP_MEM=01, OP_BR=10)
- One sub-module, alu_decoder (combinational): ALUOp, Funct -> ALUControl, FlagW. The FSM and PC logic stay in mc_control_fsm.

Test Plan:
- Reset: hold reset=1 for 2 cycles, then release -> IRWrite=1 and NextPC=1 on the first cycle after release. During reset, RegW=MemW=PCS=FlagW=0.
- LDR (Op=01, Funct=011001, Rd=3) -> FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegW=1 and ResultSrc=01 only in cycle 5; PCS=0. Back to FETCH in cycle 6.
- STR (Op=01, Funct=011000) -> MemW=1 and AdrSrc=1 in cycle 4 only; RegW=0 throughout; 4-cycle total.
- ADDS/SUBS/ANDS register (Op=00, Funct=0_0100_1, 0_0010_1, 0_0000_1) -> in EXECUTER: ALUControl=00/01/10; FlagW=11/11/10. RegW=1 in ALUWB.
- Data-processing with Rd=15 (Op=00, Funct=1_1100_0) -> EXECUTEI ALUSrcB=01, ALUControl=11, FlagW=00; PCS=1 and RegW=1 in ALUWB.
- Branch (Op=10) -> PCS=1 in cycle 3, ALUSrcB=01, ResultSrc=10. Op=11 -> FETCH after DECODE with no enables. Reset asserted in MEMADR -> FETCH next cycle and MemW never asserts.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU codes,
// datapath mux selects and instruction class (Op) codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp and the data-processing cmd/S bits to the ALU
// operation code and the unconditioned flag-write request.
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 2
) (
    input  logic                 alu_op,
    input  logic [4:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           flag_w
);

    always_comb begin
        alu_control = ALUCTRL_W'(ALU_ADD);
        flag_w      = 2'b00;
        if (alu_op) begin
            // Unsupported cmds fall through as a flagless ADD.
            case (funct[4:1])
                4'b0100: begin
                    alu_control = ALUCTRL_W'(ALU_ADD);
                    flag_w      = {funct[0], funct[0]};
                end
                4'b0010: begin
                    alu_control = ALUCTRL_W'(ALU_SUB);
                    flag_w      = {funct[0], funct[0]};
                end
                4'b0000: begin
                    alu_control = ALUCTRL_W'(ALU_AND);
                    flag_w      = {funct[0], 1'b0};
                end
                4'b1100: begin
                    alu_control = ALUCTRL_W'(ALU_ORR);
                    flag_w      = {funct[0], 1'b0};
                end
                default: begin
                    alu_control = ALUCTRL_W'(ALU_ADD);
                    flag_w      = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control front end: Moore main FSM, ALU decoder and PC-source logic.
// Enables leave here unconditioned; the downstream stage gates them with CondEx.
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W   = 2,
    parameter int RESULTSRC_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             Op,
    input  logic [5:0]             Funct,
    input  logic [3:0]             Rd,
    output logic                   PCS,
    output logic                   NextPC,
    output logic                   RegW,
    output logic                   MemW,
    output logic [1:0]             FlagW,
    output logic                   IRWrite,
    output logic                   AdrSrc,
    output logic [RESULTSRC_W-1:0] ResultSrc,
    output logic                   ALUSrcA,
    output logic [RESULTSRC_W-1:0] ALUSrcB,
    output logic [ALUCTRL_W-1:0]   ALUControl,
    output logic [1:0]             ImmSrc,
    output logic [1:0]             RegSrc
);

    state_t state;
    state_t dec_state;
    logic   alu_op;
    logic   branch;
    logic   reg_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_MEM:  state <= S_MEMADR;
                        OP_DP:   state <= Funct[5] ? S_EXECUTEI : S_EXECUTER;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:    state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWR:    state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // During reset the selects look like FETCH, but every enable is held low.
    assign dec_state = reset ? S_FETCH : state;

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        reg_w     = 1'b0;
        MemW      = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = RESULTSRC_W'(SRCB_RD2);
        ResultSrc = RESULTSRC_W'(RES_ALUOUT);
        case (dec_state)
            S_FETCH: begin
                IRWrite   = ~reset;
                NextPC    = ~reset;
                ALUSrcA   = 1'b1;
                ALUSrcB   = RESULTSRC_W'(SRCB_FOUR);
                ResultSrc = RESULTSRC_W'(RES_ALURESULT);
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = RESULTSRC_W'(SRCB_FOUR);
                ResultSrc = RESULTSRC_W'(RES_ALURESULT);
            end
            S_MEMADR: begin
                ALUSrcB = RESULTSRC_W'(SRCB_EXTIMM);
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RESULTSRC_W'(RES_DATA);
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: begin
                alu_op = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB = RESULTSRC_W'(SRCB_EXTIMM);
                alu_op  = 1'b1;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = RESULTSRC_W'(SRCB_EXTIMM);
                ResultSrc = RESULTSRC_W'(RES_ALURESULT);
                branch    = 1'b1;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

    alu_decoder #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct[4:0]),
        .alu_control (ALUControl),
        .flag_w      (FlagW)
    );

    assign RegW   = reg_w;
    assign PCS    = (reg_w & (Rd == 4'hF)) | branch;
    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM), (Op == OP_BR)};

endmodule
